// File: rtl/calc_pkg.sv
// calc_pkg: shared state, key and operator encodings for the keypad calculator
package calc_pkg;
    typedef enum logic [2:0] {IDLE, GOT_A, GOT_OP, EXEC, SHOW} state_t;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces key_pressed, emits one event per press
module key_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       key_pressed,
    output logic       press_evt,
    output logic [3:0] press_code
);
    logic [1:0]  sync;
    logic        lvl_q;
    logic        stable;
    logic [19:0] cnt;
    logic        settle;
    logic        rise;

    assign settle = (sync[1] == lvl_q) && (cnt == DEBOUNCE_CYCLES - 20'd1);
    assign rise   = settle && lvl_q && !stable;

    // synchroniser, stability counter and single-shot press event on a debounced rise
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync       <= '0;
            lvl_q      <= 1'b0;
            stable     <= 1'b0;
            cnt        <= '0;
            press_evt  <= 1'b0;
            press_code <= '0;
        end else begin
            sync      <= {sync[0], key_pressed};
            lvl_q     <= sync[1];
            cnt       <= (sync[1] != lvl_q) ? '0 : (settle ? cnt : cnt + 20'd1);
            press_evt <= rise;
            if (settle) stable <= lvl_q;
            if (rise) press_code <= key_code;
        end
    end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad calculator controller sequencing operands, operator and result display
module calc_sequencer
    import calc_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [3:0]  SETTLE_CYCLES   = 4'd4,
    parameter logic [26:0] SHOW_CYCLES     = 27'd100000000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       key_pressed,
    output logic [3:0] dp_a,
    output logic [3:0] dp_b,
    output logic       dp_mul,
    input  logic [3:0] dp_sum,
    input  logic       dp_carry,
    input  logic [7:0] dp_prod,
    output logic [7:0] led,
    output logic       busy,
    output logic       err
);
    state_t      state;
    logic [3:0]  a;
    logic        op;
    logic [3:0]  settle_cnt;
    logic [26:0] show_cnt;
    logic        press_evt;
    logic [3:0]  press_code;
    logic        digit;
    logic        valid;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .key_code   (key_code),
        .key_pressed(key_pressed),
        .press_evt  (press_evt),
        .press_code (press_code)
    );

    assign digit = press_code <= 4'd9;
    assign valid = press_code <= KEY_HASH;

    // operand/operator entry, datapath settle-and-capture, result display and timeout
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a          <= '0;
            op         <= OP_ADD;
            settle_cnt <= '0;
            show_cnt   <= '0;
            dp_a       <= '0;
            dp_b       <= '0;
            dp_mul     <= 1'b0;
            led        <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else if (state == EXEC) begin
            if (settle_cnt == SETTLE_CYCLES - 4'd1) begin
                led      <= (op == OP_MUL) ? dp_prod : {3'b000, dp_carry, dp_sum};
                state    <= SHOW;
                busy     <= 1'b0;
                show_cnt <= '0;
            end else begin
                settle_cnt <= settle_cnt + 4'd1;
            end
        end else if (press_evt && !valid) begin
            err <= 1'b1;
        end else if (press_evt) begin
            err <= 1'b0;
            case (state)
                IDLE: if (digit) begin
                    a     <= press_code;
                    led   <= {press_code, 4'h0};
                    state <= GOT_A;
                end
                GOT_A: if (digit) begin
                    a   <= press_code;
                    led <= {press_code, 4'h0};
                end else if (press_code == KEY_STAR) begin
                    op    <= OP_ADD;
                    led   <= {a, 4'hA};
                    state <= GOT_OP;
                end else begin
                    a     <= '0;
                    led   <= '0;
                    state <= IDLE;
                end
                GOT_OP: if (digit) begin
                    led        <= {a, press_code};
                    dp_a       <= a;
                    dp_b       <= press_code;
                    dp_mul     <= op;
                    busy       <= 1'b1;
                    settle_cnt <= '0;
                    state      <= EXEC;
                end else if (press_code == KEY_STAR) begin
                    op       <= ~op;
                    led[3:0] <= (op == OP_ADD) ? 4'hB : 4'hA;
                end else begin
                    led   <= '0;
                    state <= IDLE;
                end
                SHOW: if (digit) begin
                    a     <= press_code;
                    led   <= {press_code, 4'h0};
                    state <= GOT_A;
                end else begin
                    led   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end else if (state == SHOW && SHOW_CYCLES != 27'd0) begin
            if (show_cnt == SHOW_CYCLES - 27'd1) begin
                led   <= '0;
                state <= IDLE;
            end else begin
                show_cnt <= show_cnt + 27'd1;
            end
        end
    end
endmodule
